// File: rtl/pi_i2s_rx_if.sv
// Stereo frame channel from the I2S receiver to the audio mixer.
// Valid/ready: the master holds sample_valid with sample_l/sample_r stable until a clock edge sees
// sample_valid & sample_ready; that edge transfers the frame and the master may present the next one on it.
interface pi_i2s_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] sample_l;
    logic [DATA_WIDTH-1:0] sample_r;
    logic                  sample_valid;
    logic                  sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/pi_i2s_rx.sv
// Philips I2S receiver for the Pi GPIO audio stream: synchronises sclk/wclk/dout,
// deserialises left/right words and hands complete stereo frames to the mixer.
module pi_i2s_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk_peripheral,
    input  logic        reset,
    input  logic        i2s_sclk,
    input  logic        i2s_wclk,
    input  logic        i2s_dout,
    pi_i2s_rx_if.master smp,
    output logic        link_up,
    output logic        overrun,
    input  logic        clear_ovr,
    output logic        fsm_state
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic { HUNT = 1'b0, RUN = 1'b1 } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sclk_q, wclk_q, dout_q;
    logic                   sclk_s, wclk_s, dout_s, sclk_d1;
    logic                   rise, w_prev, w_chg;
    logic [TW-1:0]          idle_cnt;
    logic                   expire;
    logic [DATA_WIDTH-1:0]  shift, word_next, hold_l, hold_r;
    logic [5:0]             bit_idx;
    logic                   ch, have_l, frame_done;
    logic                   lock, word_end, bit_take;

    // All three inputs see the same delay so a rise samples wclk/dout aligned with sclk.
    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            sclk_q  <= '0;
            wclk_q  <= '0;
            dout_q  <= '0;
            sclk_d1 <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[SYNC_STAGES-2:0], i2s_sclk};
            wclk_q  <= {wclk_q[SYNC_STAGES-2:0], i2s_wclk};
            dout_q  <= {dout_q[SYNC_STAGES-2:0], i2s_dout};
            sclk_d1 <= sclk_s;
        end
    end

    assign sclk_s = sclk_q[SYNC_STAGES-1];
    assign wclk_s = wclk_q[SYNC_STAGES-1];
    assign dout_s = dout_q[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d1;
    assign w_chg  = wclk_s != w_prev;
    assign expire = (idle_cnt == TW'(TIMEOUT - 1)) & ~rise;

    always_ff @(posedge clk_peripheral) begin
        if (reset) state <= HUNT;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        lock     = 1'b0;
        word_end = 1'b0;
        bit_take = 1'b0;
        if (rise) begin
            if (state == HUNT) begin
                if (w_chg) begin
                    state_n = RUN;
                    lock    = 1'b1;
                end
            end else if (w_chg) begin
                word_end = 1'b1;
            end else begin
                bit_take = 1'b1;
            end
        end else if (expire) begin
            state_n = HUNT;
        end
    end

    // Current shift register with this rise's bit placed; slots past DATA_WIDTH leave it untouched.
    always_comb begin
        word_next = shift;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_idx == 6'(DATA_WIDTH - 1 - i)) word_next[i] = dout_s;
        end
    end

    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            w_prev     <= 1'b0;
            idle_cnt   <= '0;
            shift      <= '0;
            bit_idx    <= '0;
            ch         <= 1'b0;
            have_l     <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (rise) w_prev <= wclk_s;
            if (rise || expire) idle_cnt <= '0;
            else                idle_cnt <= idle_cnt + TW'(1);

            if (lock) begin
                shift   <= '0;
                bit_idx <= '0;
                ch      <= wclk_s;
                have_l  <= 1'b0;
            end else if (bit_take) begin
                shift <= word_next;
                if (bit_idx != 6'd63) bit_idx <= bit_idx + 6'd1;
            end else if (word_end) begin
                shift   <= '0;
                bit_idx <= '0;
                ch      <= wclk_s;
                if (!ch) begin
                    hold_l <= word_next;
                    have_l <= 1'b1;
                end else begin
                    hold_r <= word_next;
                    // A right word without a preceding left word is discarded here.
                    if (have_l) begin
                        frame_done <= 1'b1;
                        have_l     <= 1'b0;
                    end
                end
            end else if (expire) begin
                have_l <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_peripheral) begin
        if (reset) begin
            smp.sample_l     <= '0;
            smp.sample_r     <= '0;
            smp.sample_valid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            if (frame_done && (!smp.sample_valid || smp.sample_ready)) begin
                smp.sample_l     <= hold_l;
                smp.sample_r     <= hold_r;
                smp.sample_valid <= 1'b1;
            end else if (smp.sample_valid && smp.sample_ready) begin
                smp.sample_valid <= 1'b0;
            end

            if (frame_done && smp.sample_valid && !smp.sample_ready) overrun <= 1'b1;
            else if (clear_ovr)                                       overrun <= 1'b0;
        end
    end

    assign link_up   = (state == RUN);
    assign fsm_state = state;
endmodule

// File: tb/tb_pi_i2s_rx.sv
// Directed bench for pi_i2s_rx: drives a Philips I2S stream at the pins and
// checks delivered frames, latency, overrun, timeout and reset behaviour.
module tb_pi_i2s_rx;
    localparam int DW   = 16;
    localparam int SS   = 2;
    localparam int TO   = 4096;
    localparam int HALF = 4;

    logic clk_peripheral = 1'b0;
    logic reset          = 1'b1;
    logic i2s_sclk       = 1'b0;
    logic i2s_wclk       = 1'b0;
    logic i2s_dout       = 1'b0;
    logic clear_ovr      = 1'b0;
    logic link_up, overrun, fsm_state;

    pi_i2s_rx_if #(.DATA_WIDTH(DW)) smp_if ();

    pi_i2s_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk_peripheral (clk_peripheral),
        .reset          (reset),
        .i2s_sclk       (i2s_sclk),
        .i2s_wclk       (i2s_wclk),
        .i2s_dout       (i2s_dout),
        .smp            (smp_if),
        .link_up        (link_up),
        .overrun        (overrun),
        .clear_ovr      (clear_ovr),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_peripheral = ~clk_peripheral;

    int cyc = 0;
    always @(posedge clk_peripheral) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int last_rise_cyc = 0;
    logic [2*DW-1:0] exp_q[$];
    int              lat_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_peripheral);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Data and word select change while sclk is low; the Pi's rising edge follows HALF cycles later.
    task automatic send_bit(input logic w, input logic d);
        i2s_sclk = 1'b0;
        i2s_wclk = w;
        i2s_dout = d;
        repeat (HALF) tick();
        i2s_sclk      = 1'b1;
        last_rise_cyc = cyc;
        repeat (HALF) tick();
    endtask

    // v is left-justified; the slot's final bit goes out with word select already toggled.
    task automatic send_slot(input logic chw, input logic [63:0] v, input int n,
                             input int from, input int to);
        for (int i = from; i <= to; i++) send_bit((i == n - 1) ? ~chw : chw, v[63-i]);
    endtask

    task automatic send_frame(input logic [63:0] vl, input logic [63:0] vr, input int n,
                              input logic [DW-1:0] el, input logic [DW-1:0] er,
                              input bit deliver, input bit lat);
        send_slot(1'b0, vl, n, 0, n - 1);
        send_slot(1'b1, vr, n, 0, n - 2);
        if (deliver) exp_q.push_back({el, er});
        if (lat) lat_q.push_back(cyc + HALF + SS + 2);
        send_bit(1'b0, vr[64-n]);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 64; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- scoreboard monitor ----------------
    logic            prev_valid = 1'b0;
    int              exp_lat;
    logic [2*DW-1:0] exp_frame;

    always @(negedge clk_peripheral) begin
        if (!reset) begin
            if (smp_if.sample_valid && !prev_valid && lat_q.size() > 0) begin
                exp_lat = lat_q.pop_front();
                check("valid_latency", cyc, exp_lat);
            end
            if (smp_if.sample_valid && smp_if.sample_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got 0x%0h/0x%0h, expected no frame",
                             smp_if.sample_l, smp_if.sample_r);
                end else begin
                    exp_frame = exp_q.pop_front();
                    check("frame_data", {smp_if.sample_l, smp_if.sample_r}, exp_frame);
                end
            end
        end
        prev_valid = smp_if.sample_valid;
    end

    // ---------------- stimulus ----------------
    initial begin
        smp_if.sample_ready = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        tick();
        check("rst_sample_l", smp_if.sample_l, 0);
        check("rst_sample_r", smp_if.sample_r, 0);
        check("rst_valid", smp_if.sample_valid, 0);
        check("rst_link_up", link_up, 0);
        check("rst_overrun", overrun, 0);
        check("rst_fsm_hunt", fsm_state, 0);

        // 32-bit slots; the partial first frame must be discarded
        smp_if.sample_ready = 1'b1;
        send_slot(1'b0, 64'hA5C3_0000_0000_0000, 32, 0, 30);
        check("link_before_lock", link_up, 0);
        send_slot(1'b0, 64'hA5C3_0000_0000_0000, 32, 31, 31);
        check("link_at_lock", link_up, 1);
        send_slot(1'b1, 64'h1234_0000_0000_0000, 32, 0, 31);
        for (int f = 0; f < 2; f++)
            send_frame(64'hA5C3_0000_0000_0000, 64'h1234_0000_0000_0000, 32,
                       16'hA5C3, 16'h1234, 1'b1, 1'b1);
        repeat (4) tick();
        check("pulse_done", smp_if.sample_valid, 0);

        // 8-bit slots are zero-padded in the LSBs
        send_frame(64'hAB00_0000_0000_0000, 64'hCD00_0000_0000_0000, 8,
                   16'hAB00, 16'hCD00, 1'b1, 1'b0);
        repeat (4) tick();

        // back-pressure across two frames: second one dropped
        smp_if.sample_ready = 1'b0;
        send_frame(64'h1111_0000_0000_0000, 64'h2222_0000_0000_0000, 32,
                   16'h1111, 16'h2222, 1'b1, 1'b0);
        send_frame(64'h3333_0000_0000_0000, 64'h4444_0000_0000_0000, 32,
                   16'h3333, 16'h4444, 1'b0, 1'b0);
        repeat (3) tick();
        check("held_sample_l", smp_if.sample_l, 16'h1111);
        check("held_sample_r", smp_if.sample_r, 16'h2222);
        check("held_valid", smp_if.sample_valid, 1);
        check("overrun_set", overrun, 1);
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
        tick();
        check("overrun_cleared", overrun, 0);
        smp_if.sample_ready = 1'b1;
        wait_drain("drain_held");

        // sclk stops: link drops exactly TIMEOUT cycles after the last rise is seen
        for (int k = 0; k < TO + 64; k++) begin
            if (!link_up) break;
            tick();
        end
        check("timeout_cycles", cyc - last_rise_cyc, SS + 1 + TO);
        check("timeout_link_down", link_up, 0);
        send_frame(64'h5A5A_0000_0000_0000, 64'h0F0F_0000_0000_0000, 32,
                   16'h5A5A, 16'h0F0F, 1'b0, 1'b0);
        check("relock_link_up", link_up, 1);
        send_frame(64'h5A5A_0000_0000_0000, 64'h0F0F_0000_0000_0000, 32,
                   16'h5A5A, 16'h0F0F, 1'b1, 1'b0);
        wait_drain("drain_resync");

        // reset in the middle of a left word
        send_slot(1'b0, 64'hBEEF_0000_0000_0000, 32, 0, 9);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("midrst_sample_l", smp_if.sample_l, 0);
        check("midrst_sample_r", smp_if.sample_r, 0);
        check("midrst_valid", smp_if.sample_valid, 0);
        check("midrst_link_up", link_up, 0);
        check("midrst_overrun", overrun, 0);
        send_slot(1'b0, 64'hBEEF_0000_0000_0000, 32, 10, 31);
        send_slot(1'b1, 64'hCAFE_0000_0000_0000, 32, 0, 31);
        repeat (4) tick();
        check("midrst_no_frame", smp_if.sample_valid, 0);
        check("midrst_relock", link_up, 1);
        send_frame(64'hBEEF_0000_0000_0000, 64'hCAFE_0000_0000_0000, 32,
                   16'hBEEF, 16'hCAFE, 1'b1, 1'b0);
        wait_drain("drain_midrst");

        // ready arrives in the very cycle the next frame completes
        smp_if.sample_ready = 1'b0;
        send_frame(64'h7777_0000_0000_0000, 64'h8888_0000_0000_0000, 32,
                   16'h7777, 16'h8888, 1'b1, 1'b0);
        repeat (2) tick();
        check("b2b_first_valid", smp_if.sample_valid, 1);
        send_slot(1'b0, 64'h9999_0000_0000_0000, 32, 0, 31);
        send_slot(1'b1, 64'hAAAA_0000_0000_0000, 32, 0, 30);
        exp_q.push_back({16'h9999, 16'hAAAA});
        i2s_sclk = 1'b0;
        i2s_wclk = 1'b0;
        i2s_dout = 1'b0;
        repeat (HALF) tick();
        i2s_sclk = 1'b1;
        repeat (SS + 1) tick();
        smp_if.sample_ready = 1'b1;
        tick();
        smp_if.sample_ready = 1'b0;
        repeat (HALF - SS - 2) tick();
        check("b2b_sample_l", smp_if.sample_l, 16'h9999);
        check("b2b_sample_r", smp_if.sample_r, 16'hAAAA);
        check("b2b_valid", smp_if.sample_valid, 1);
        check("b2b_overrun", overrun, 0);
        smp_if.sample_ready = 1'b1;
        wait_drain("drain_b2b");

        // ---------------- final report ----------------
        repeat (4) tick();
        check("exp_queue_empty", exp_q.size(), 0);
        check("lat_queue_empty", lat_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pi_i2s_rx.md
Name: pi_i2s_rx

Overview:
- Receives the Philips-format I2S stream that the Raspberry Pi drives onto GPIO 18/19/20 (sclk, wclk, dout) after the Pi GPIO pin bridge.
- Deserialises the stream into parallel left/right PCM samples in the clk_peripheral domain.
- Presents each stereo frame to the downstream audio mixer through a valid/ready handshake.
- Includes link-up detection, an inactivity timeout and a sticky overrun flag.

Parameters:
- DATA_WIDTH, 16: bits kept per channel, MSB-first, left-justified.
- SYNC_STAGES, 2: synchroniser flops on each I2S input (minimum 2).
- TIMEOUT, 4096: clk_peripheral cycles with no sclk rising edge before the link drops.

Ports:
- clk_peripheral  in  1  peripheral clock; must be at least 4x the sclk frequency.
- reset  in  1  synchronous, active-high.
- i2s_sclk  in  1  bit clock from the Pi; asynchronous.
- i2s_wclk  in  1  word select; 0 = left, 1 = right; asynchronous.
- i2s_dout  in  1  serial data from the Pi; asynchronous.
- sample_l  out  DATA_WIDTH  left sample of the last completed frame.
- sample_r  out  DATA_WIDTH  right sample of the last completed frame.
- sample_valid  out  1  frame available.
- sample_ready  in  1  consumer accepts the frame.
- link_up  out  1  framing locked.
- overrun  out  1  sticky; a frame was dropped.
- clear_ovr  in  1  clears overrun.

Behaviour:
- Reset: already decided — reset is synchronous and active-high; the clock is clk_peripheral.
- Reset values:
  - sample_l = 0, sample_r = 0, sample_valid = 0, link_up = 0, overrun = 0.
  - All synchroniser, shift, counter and timeout registers = 0.
  - FSM = HUNT.
  - Reset mid-word discards all partial data.
- Input path:
  - sclk, wclk and dout each pass through SYNC_STAGES flops.
  - rise = sclk_s & ~sclk_s_d1. All sampling happens only on rise cycles; all three inputs share equal delay.
- Edge handling: on each rise, capture d = dout_s and w = wclk_s; w_prev holds w from the previous rise.
- FSM states:
  - HUNT: on a rise with w != w_prev → RUN, bit_idx = 0, shift = 0, ch = w; nothing output.
  - RUN, rise with w == w_prev: if bit_idx < DATA_WIDTH, write shift[DATA_WIDTH-1-bit_idx] = d. Then bit_idx = bit_idx + 1, saturating at 63.
  - RUN, rise with w != w_prev (transition edge, carrying the last bit of the current slot):
    - Place d as above if bit_idx < DATA_WIDTH.
    - Store the finished word into hold_l (ch = 0) or hold_r (ch = 1).
    - Clear shift, set bit_idx = 0, set ch = w.
    - When the finished word is right and have_l = 1, the frame completes.
  - have_l: set when a left word is stored; cleared on frame completion and on entering HUNT. A right word completing without have_l set is dropped silently.
- Slot lengths:
  - Slots shorter than DATA_WIDTH are zero-padded in the LSBs.
  - Bits beyond DATA_WIDTH are ignored. Any slot length from 1 to 64 is accepted.
- Frame completion:
  - If sample_valid = 0, or sample_valid & sample_ready in the same cycle: load sample_l = hold_l, sample_r = hold_r and set sample_valid = 1 on the next clock.
  - Otherwise the frame is dropped, the outputs are unchanged and overrun is set.
- Handshake:
  - sample_valid is held with stable data until sample_ready; the clock edge with valid & ready clears it unless a new frame loads in the same cycle.
  - Latency: sample_valid rises exactly SYNC_STAGES+2 cycles after the pin-level sclk rise that samples the final right bit.
- link_up = 1 in RUN and 0 in HUNT.
- Timeout:
  - A counter clears on every rise and increments otherwise.
  - Reaching TIMEOUT → HUNT, have_l = 0, link_up = 0.
  - A pending sample_valid is retained.
- overrun:
  - Set on a dropped frame; cleared by clear_ovr.
  - When both occur in the same cycle, set wins.
- Simultaneous events: a rise together with a timeout expiry → the rise wins and the counter clears.

Test Plan:
- After reset, Pi sends 3 frames, 32-bit slots, L = 0xA5C3, R = 0x1234, sample_ready = 1:
  - The first partial frame is discarded; link_up rises at the first wclk transition.
  - Two frames are delivered with sample_l = 0xA5C3, sample_r = 0x1234, each sample_valid a 1-cycle pulse, SYNC_STAGES+2 cycles after the final right bit.
- 8-bit slots, L = 0xAB, R = 0xCD → sample_l = 0xAB00, sample_r = 0xCD00.
- Hold sample_ready = 0 across 2 frames (0x1111/0x2222, then 0x3333/0x4444):
  - The outputs stay at 0x1111/0x2222 and overrun = 1.
  - Pulsing clear_ovr with no new drop → overrun = 0.
- Stop sclk after link lock:
  - link_up = 0 exactly TIMEOUT cycles after the last rise.
  - On restart, the first post-resync frame is delivered correctly.
- Assert reset mid-left-word, then resume the stream:
  - All outputs are 0.
  - No sample_valid until a full left+right frame is received after the first new wclk transition.
- Drive sample_ready = 1 in the same cycle a new frame completes while sample_valid = 1:
  - The new frame loads with no gap: sample_valid stays 1 and overrun stays 0.
